// File: rtl/edge_overlay_pkg.sv
// Shared types and constants for the edge bounding-box overlay.
// Contents: coordinate width helper, default box colour, white/black pixels,
// and the packed video bus payload used for pipeline staging.
package edge_overlay_pkg;

  localparam int unsigned PIX_W = 24;

  localparam logic [PIX_W-1:0] BOX_COLOR_DEF = 24'hFF0000;
  localparam logic [PIX_W-1:0] PIX_WHITE     = 24'hFFFFFF;
  localparam logic [PIX_W-1:0] PIX_BLACK     = 24'h000000;

  // One pixel-clock beat of the video bus.
  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             vde;
    logic             hsync;
    logic             vsync;
  } vid_t;

  // Bits needed to index n positions (never below 1).
  function automatic int unsigned coord_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_bbox_acc.sv
// Per-frame edge statistics: counts edge pixels and tracks their bounding box.
// On frame_start the running totals are published (once armed) and restarted.
// Ports: pclk/rst_n; frame_start (vsync rise), pix_edge, x, y (current pixel);
// edge_count, bbox_min/max_x/y, bbox_valid, stat_valid (registered results).
module frame_bbox_acc #(
  parameter int unsigned XW         = 11,
  parameter int unsigned YW         = 10,
  parameter int unsigned CW         = 21,
  parameter int unsigned MIN_PIXELS = 64
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          pix_edge,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [CW-1:0] edge_count,
  output logic [XW-1:0] bbox_min_x,
  output logic [XW-1:0] bbox_max_x,
  output logic [YW-1:0] bbox_min_y,
  output logic [YW-1:0] bbox_max_y,
  output logic          bbox_valid,
  output logic          stat_valid
);

  logic [CW-1:0] acc_cnt, cnt_n;
  logic [XW-1:0] acc_minx, acc_maxx, minx_n, maxx_n;
  logic [YW-1:0] acc_miny, acc_maxy, miny_n, maxy_n;
  logic          frame_seen;

  // Restart on the boundary first, so a coincident edge pixel lands in the new frame.
  always_comb begin
    cnt_n  = acc_cnt;
    minx_n = acc_minx;
    maxx_n = acc_maxx;
    miny_n = acc_miny;
    maxy_n = acc_maxy;
    if (frame_start) begin
      cnt_n  = '0;
      minx_n = '1;
      maxx_n = '0;
      miny_n = '1;
      maxy_n = '0;
    end
    if (pix_edge) begin
      if (cnt_n != '1) cnt_n = cnt_n + CW'(1);
      if (x < minx_n) minx_n = x;
      if (x > maxx_n) maxx_n = x;
      if (y < miny_n) miny_n = y;
      if (y > maxy_n) maxy_n = y;
    end
  end

  // Accumulators, plus publish of the finished frame (skipped for the partial first frame).
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt    <= '0;
      acc_minx   <= '1;
      acc_maxx   <= '0;
      acc_miny   <= '1;
      acc_maxy   <= '0;
      frame_seen <= 1'b0;
      edge_count <= '0;
      bbox_min_x <= '0;
      bbox_max_x <= '0;
      bbox_min_y <= '0;
      bbox_max_y <= '0;
      bbox_valid <= 1'b0;
      stat_valid <= 1'b0;
    end else begin
      acc_cnt    <= cnt_n;
      acc_minx   <= minx_n;
      acc_maxx   <= maxx_n;
      acc_miny   <= miny_n;
      acc_maxy   <= maxy_n;
      stat_valid <= 1'b0;
      if (frame_start) begin
        frame_seen <= 1'b1;
        if (frame_seen) begin
          edge_count <= acc_cnt;
          bbox_min_x <= acc_minx;
          bbox_max_x <= acc_maxx;
          bbox_min_y <= acc_miny;
          bbox_max_y <= acc_maxy;
          bbox_valid <= (acc_cnt >= CW'(MIN_PIXELS));
          stat_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/edge_bbox_overlay.sv
// Binarises Sobel magnitude, gathers per-frame edge statistics and draws the
// previous frame's edge bounding box onto the outgoing video (2 pclk latency).
// Ports: pclk/rst_n; s_pData/s_pVDE/s_pHSync/s_pVSync in; thresh, bin_en;
// m_pData/m_pVDE/m_pHSync/m_pVSync out; edge_count, bbox_*, bbox_valid, stat_valid.
module edge_bbox_overlay
  import edge_overlay_pkg::*;
#(
  parameter int unsigned      H_ACTIVE   = 1280,
  parameter int unsigned      V_ACTIVE   = 720,
  parameter int unsigned      MIN_PIXELS = 64,
  parameter logic [PIX_W-1:0] BOX_COLOR  = BOX_COLOR_DEF,
  localparam int unsigned     XW         = coord_w(H_ACTIVE),
  localparam int unsigned     YW         = coord_w(V_ACTIVE),
  localparam int unsigned     CW         = XW + YW
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] s_pData,
  input  logic             s_pVDE,
  input  logic             s_pHSync,
  input  logic             s_pVSync,
  input  logic [7:0]       thresh,
  input  logic             bin_en,
  output logic [PIX_W-1:0] m_pData,
  output logic             m_pVDE,
  output logic             m_pHSync,
  output logic             m_pVSync,
  output logic [CW-1:0]    edge_count,
  output logic [XW-1:0]    bbox_min_x,
  output logic [XW-1:0]    bbox_max_x,
  output logic [YW-1:0]    bbox_min_y,
  output logic [YW-1:0]    bbox_max_y,
  output logic             bbox_valid,
  output logic             stat_valid
);

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic          vs_d, vde_d;
  logic [XW-1:0] x_cnt, s1_x;
  logic [YW-1:0] y_cnt, s1_y;
  logic [7:0]    thresh_q;
  logic          vs_rise_c, eol_c, edge_c, on_box_c;
  logic          s1_edge, s1_bin;
  vid_t          s1;
  logic [PIX_W-1:0] pix_c;

  assign vs_rise_c = s_pVSync & ~vs_d;
  assign eol_c     = vde_d & ~s_pVDE;
  assign edge_c    = s_pVDE && (s_pData[7:0] >= thresh_q);

  // Raster position of the current input pixel and per-frame threshold.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d     <= 1'b0;
      vde_d    <= 1'b0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      thresh_q <= '0;
    end else begin
      vs_d  <= s_pVSync;
      vde_d <= s_pVDE;
      if (vs_rise_c) begin
        x_cnt    <= '0;
        y_cnt    <= '0;
        thresh_q <= thresh;
      end else if (eol_c) begin
        x_cnt <= '0;
        if (y_cnt != Y_LAST) y_cnt <= y_cnt + YW'(1);
      end else if (s_pVDE && (x_cnt != X_LAST)) begin
        x_cnt <= x_cnt + XW'(1);
      end
    end
  end

  frame_bbox_acc #(
    .XW         (XW),
    .YW         (YW),
    .CW         (CW),
    .MIN_PIXELS (MIN_PIXELS)
  ) u_acc (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .frame_start (vs_rise_c),
    .pix_edge    (edge_c),
    .x           (x_cnt),
    .y           (y_cnt),
    .edge_count  (edge_count),
    .bbox_min_x  (bbox_min_x),
    .bbox_max_x  (bbox_max_x),
    .bbox_min_y  (bbox_min_y),
    .bbox_max_y  (bbox_max_y),
    .bbox_valid  (bbox_valid),
    .stat_valid  (stat_valid)
  );

  // Box perimeter test against last frame's published box.
  assign on_box_c = (((s1_x == bbox_min_x) || (s1_x == bbox_max_x)) &&
                     (s1_y >= bbox_min_y) && (s1_y <= bbox_max_y)) ||
                    (((s1_y == bbox_min_y) || (s1_y == bbox_max_y)) &&
                     (s1_x >= bbox_min_x) && (s1_x <= bbox_max_x));

  // Overlay mux: blanking black, box wins over binarised/pass-through video.
  always_comb begin
    pix_c = PIX_BLACK;
    if (s1.vde) begin
      if (bbox_valid && on_box_c) pix_c = BOX_COLOR;
      else if (s1_bin)            pix_c = s1_edge ? PIX_WHITE : PIX_BLACK;
      else                        pix_c = s1.data;
    end
  end

  // Stage 1 captures pixel + classification, stage 2 drives the overlaid bus.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      s1_edge  <= 1'b0;
      s1_bin   <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      m_pData  <= '0;
      m_pVDE   <= 1'b0;
      m_pHSync <= 1'b0;
      m_pVSync <= 1'b0;
    end else begin
      s1       <= '{data: s_pData, vde: s_pVDE, hsync: s_pHSync, vsync: s_pVSync};
      s1_edge  <= edge_c;
      s1_bin   <= bin_en;
      s1_x     <= x_cnt;
      s1_y     <= y_cnt;
      m_pData  <= pix_c;
      m_pVDE   <= s1.vde;
      m_pHSync <= s1.hsync;
      m_pVSync <= s1.vsync;
    end
  end

endmodule

// File: tb/tb_edge_bbox_overlay.sv
// Scoreboard bench for edge_bbox_overlay: a reference model predicts every
// output beat and each frame's published statistics.
module tb_edge_bbox_overlay;
  import edge_overlay_pkg::*;

  localparam int unsigned H    = 128;
  localparam int unsigned V    = 64;
  localparam int unsigned MINP = 64;
  localparam int unsigned XW   = 7;
  localparam int unsigned YW   = 6;
  localparam int unsigned CW   = XW + YW;

  logic          pclk, rst_n;
  logic [23:0]   s_pData, m_pData;
  logic          s_pVDE, s_pHSync, s_pVSync, m_pVDE, m_pHSync, m_pVSync;
  logic [7:0]    thresh;
  logic          bin_en;
  logic [CW-1:0] edge_count;
  logic [XW-1:0] bbox_min_x, bbox_max_x;
  logic [YW-1:0] bbox_min_y, bbox_max_y;
  logic          bbox_valid, stat_valid;

  edge_bbox_overlay #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .MIN_PIXELS (MINP)
  ) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .s_pData    (s_pData),
    .s_pVDE     (s_pVDE),
    .s_pHSync   (s_pHSync),
    .s_pVSync   (s_pVSync),
    .thresh     (thresh),
    .bin_en     (bin_en),
    .m_pData    (m_pData),
    .m_pVDE     (m_pVDE),
    .m_pHSync   (m_pHSync),
    .m_pVSync   (m_pVSync),
    .edge_count (edge_count),
    .bbox_min_x (bbox_min_x),
    .bbox_max_x (bbox_max_x),
    .bbox_min_y (bbox_min_y),
    .bbox_max_y (bbox_max_y),
    .bbox_valid (bbox_valid),
    .stat_valid (stat_valid)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Bench-side controls, applied to the DUT in step with pixel data.
  logic [7:0] tb_thresh;
  logic       tb_bin;

  // Reference model state.
  logic [XW-1:0] m_x, o_minx, o_maxx, a_minx, a_maxx;
  logic [YW-1:0] m_y, o_miny, o_maxy, a_miny, a_maxy;
  logic [CW-1:0] a_cnt, o_cnt;
  logic          m_vs_d, m_vde_d, m_seen, o_val, stat_pend;
  logic [7:0]    m_thq;
  logic [26:0]   sb_q[$];

  task automatic model_reset();
    m_x = '0; m_y = '0; m_vs_d = 1'b0; m_vde_d = 1'b0; m_seen = 1'b0; m_thq = '0;
    a_cnt = '0; a_minx = '1; a_maxx = '0; a_miny = '1; a_maxy = '0;
    o_cnt = '0; o_minx = '0; o_maxx = '0; o_miny = '0; o_maxy = '0; o_val = 1'b0;
    stat_pend = 1'b0;
    sb_q.delete();
  endtask

  // One pixel clock: compare what is due, predict the new beat, drive it.
  task automatic drive(input logic [23:0] d, input logic vde, input logic hs, input logic vs);
    logic        vsr, edg, onb;
    logic [23:0] ep;
    @(negedge pclk);
    if (sb_q.size() >= 2) check("video", {m_pData, m_pVDE, m_pHSync, m_pVSync}, sb_q.pop_front());
    check("stat_valid", stat_valid, stat_pend);
    if (stat_pend) begin
      check("edge_count", edge_count, o_cnt);
      check("min_x", bbox_min_x, o_minx);
      check("max_x", bbox_max_x, o_maxx);
      check("min_y", bbox_min_y, o_miny);
      check("max_y", bbox_max_y, o_maxy);
      check("bbox_valid", bbox_valid, o_val);
    end
    vsr = vs && !m_vs_d;
    edg = vde && (d[7:0] >= m_thq);
    onb = ((m_x == o_minx || m_x == o_maxx) && m_y >= o_miny && m_y <= o_maxy) ||
          ((m_y == o_miny || m_y == o_maxy) && m_x >= o_minx && m_x <= o_maxx);
    if (!vde)             ep = 24'h000000;
    else if (o_val && onb) ep = 24'hFF0000;
    else if (tb_bin)      ep = edg ? 24'hFFFFFF : 24'h000000;
    else                  ep = d;
    sb_q.push_back({ep, vde, hs, vs});
    stat_pend = 1'b0;
    if (vsr) begin
      if (m_seen) begin
        o_cnt = a_cnt; o_minx = a_minx; o_maxx = a_maxx; o_miny = a_miny; o_maxy = a_maxy;
        o_val = (a_cnt >= CW'(MINP));
        stat_pend = 1'b1;
      end
      m_seen = 1'b1;
      m_thq  = tb_thresh;
      a_cnt = '0; a_minx = '1; a_maxx = '0; a_miny = '1; a_maxy = '0;
    end
    if (edg) begin
      if (a_cnt != '1) a_cnt = a_cnt + CW'(1);
      if (m_x < a_minx) a_minx = m_x;
      if (m_x > a_maxx) a_maxx = m_x;
      if (m_y < a_miny) a_miny = m_y;
      if (m_y > a_maxy) a_maxy = m_y;
    end
    if (vsr) begin
      m_x = '0; m_y = '0;
    end else if (m_vde_d && !vde) begin
      m_x = '0;
      if (m_y != YW'(V - 1)) m_y = m_y + YW'(1);
    end else if (vde && m_x != XW'(H - 1)) begin
      m_x = m_x + XW'(1);
    end
    m_vs_d = vs; m_vde_d = vde;
    s_pData = d; s_pVDE = vde; s_pHSync = hs; s_pVSync = vs;
    thresh = tb_thresh; bin_en = tb_bin;
  endtask

  function automatic logic [23:0] pix(input int kind, input int x, input int y);
    case (kind)
      1: return (x == 10 && y == 5) ? 24'h0000C8 : 24'h334400;
      2: return (x >= 100 && x <= 109 && y >= 50 && y <= 59) ? 24'h5500C8 : 24'h550010;
      3: return (y == 0 && x < 10) ? 24'h0000FF : 24'h000000;
      4: return {8'h20, 8'h30, 8'(x * 2)};
      5: return (x % 2 == 1) ? 24'h000080 : 24'h00007F;
      6: return {8'(x), 8'(y), 8'h00};
      default: return 24'h000000;
    endcase
  endfunction

  task automatic frame(input int kind, input int nlines, input int npix,
                       input int chg_line, input logic [7:0] chg_val);
    drive(24'h0, 1'b0, 1'b0, 1'b1);
    drive(24'h0, 1'b0, 1'b0, 1'b1);
    drive(24'h0, 1'b0, 1'b0, 1'b0);
    drive(24'h0, 1'b0, 1'b0, 1'b0);
    for (int l = 0; l < nlines; l++) begin
      if (l == chg_line) tb_thresh = chg_val;
      for (int p = 0; p < npix; p++) drive(pix(kind, p, l), 1'b1, 1'b0, 1'b0);
      for (int b = 0; b < 4; b++) drive(24'h0, 1'b0, (b == 1 || b == 2), 1'b0);
    end
  endtask

  task automatic check_stats(input string tag, input int cnt, input int x0, input int x1,
                             input int y0, input int y1, input logic val);
    check({tag, "_count"}, edge_count, cnt);
    check({tag, "_min_x"}, bbox_min_x, x0);
    check({tag, "_max_x"}, bbox_max_x, x1);
    check({tag, "_min_y"}, bbox_min_y, y0);
    check({tag, "_max_y"}, bbox_max_y, y1);
    check({tag, "_valid"}, bbox_valid, val);
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst_n = 1'b0;
    s_pData = '0; s_pVDE = 1'b0; s_pHSync = 1'b0; s_pVSync = 1'b0;
    #1;
    check("rst_data", m_pData, 0);
    check("rst_vde", m_pVDE, 0);
    check("rst_hs", m_pHSync, 0);
    check("rst_vs", m_pVSync, 0);
    check("rst_stat_valid", stat_valid, 0);
    check_stats("rst", 0, 0, 0, 0, 0, 1'b0);
    model_reset();
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    s_pData = '0; s_pVDE = 1'b0; s_pHSync = 1'b0; s_pVSync = 1'b0;
    tb_thresh = 8'd100; tb_bin = 1'b0;
    thresh = tb_thresh; bin_en = tb_bin;
    model_reset();
    do_reset();

    // First boundary only arms; single edge pixel at (10,5).
    frame(1, 8, 16, -1, 8'd0);
    tb_thresh = 8'd128;
    frame(0, 2, 16, -1, 8'd0);
    check_stats("single", 1, 10, 10, 5, 5, 1'b0);

    // 10x10 edge block, then a ramp frame carrying the drawn box.
    frame(2, 61, 112, -1, 8'd0);
    frame(6, 61, 112, -1, 8'd0);
    check_stats("block", 100, 100, 109, 50, 59, 1'b1);

    // Ten edge pixels: below MIN_PIXELS, nothing drawn.
    frame(3, 2, 16, -1, 8'd0);
    tb_thresh = 8'd50;
    frame(0, 2, 16, -1, 8'd0);
    check_stats("ten", 10, 0, 9, 0, 0, 1'b0);

    // Threshold 50 latched; change to 250 mid-frame has no effect until next boundary.
    frame(4, 2, 64, 1, 8'd250);
    frame(0, 2, 64, -1, 8'd0);
    check_stats("thr", 78, 25, 63, 0, 1, 1'b1);

    // Binarised output around the 128 threshold.
    tb_thresh = 8'd128;
    frame(0, 1, 8, -1, 8'd0);
    tb_bin = 1'b1;
    frame(5, 1, 8, -1, 8'd0);
    tb_bin = 1'b0;

    // Reset in the middle of an active line; next boundary must only re-arm.
    drive(24'h0, 1'b0, 1'b0, 1'b1);
    drive(24'h0, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++) drive(pix(6, p, 0), 1'b1, 1'b0, 1'b0);
    do_reset();
    frame(1, 8, 16, -1, 8'd0);
    frame(0, 1, 16, -1, 8'd0);
    check_stats("post_rst", 1, 10, 10, 5, 5, 1'b0);

    repeat (4) drive(24'h0, 1'b0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
